// File: rtl/noise_pkg.sv
// Shared constants and helpers for the noise channel array: LFSR taps,
// per-channel seed spreading, hit-probability clamp and default sizes.
package noise_pkg;

    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [31:0] SEED_SPREAD  = 32'h9E37_79B9;
    localparam logic [3:0]  PROB_SEL_MAX = 4'd8;

    localparam int DEFAULT_NUM_CH = 8;
    localparam int DEFAULT_ACC_W  = 16;

    function automatic logic [3:0] clamp_prob(input logic [3:0] sel);
        return (sel > PROB_SEL_MAX) ? PROB_SEL_MAX : sel;
    endfunction

    // Mask of the low n bits; n is already clamped to 0..8.
    function automatic logic [7:0] hit_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/noise_lfsr32.sv
// Free-running 32-bit Fibonacci LFSR with zero-lockup recovery; only the
// low byte is exported since hit detection looks at no more than 8 bits.
module noise_lfsr32
    import noise_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hDEAD_BEEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_low_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic        fb;

    always_comb begin
        fb = lfsr_q[TAP_A] ^ lfsr_q[TAP_B] ^ lfsr_q[TAP_C] ^ lfsr_q[TAP_D];
        if (lfsr_q == '0) begin
            lfsr_d = SEED ^ 32'h1;
        end else begin
            lfsr_d = {lfsr_q[30:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_low_o = lfsr_q[7:0];

endmodule

// File: rtl/noise_channel_array.sv
// Array of random-hit accumulators with latched per-channel error flags and a
// round-robin, single-slot error-event output stream.
module noise_channel_array
    import noise_pkg::*;
#(
    parameter int          NUM_CH = DEFAULT_NUM_CH,
    parameter int          ACC_W  = DEFAULT_ACC_W,
    parameter logic [31:0] SEED   = 32'hDEAD_BEEF,
    localparam int         CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_evolution,
    input  logic [3:0]        prob_sel,
    input  logic [ACC_W-1:0]  threshold,
    input  logic              corr_valid,
    input  logic [NUM_CH-1:0] corr_mask,
    output logic [NUM_CH-1:0] error_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic [ACC_W-1:0]  evt_acc
);

    function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [7:0]        lfsr_low [NUM_CH];
    logic [ACC_W-1:0]  acc_q    [NUM_CH];
    logic [ACC_W-1:0]  acc_d    [NUM_CH];
    logic [NUM_CH-1:0] err_q, err_d, pend_q, pend_d;
    logic [NUM_CH-1:0] hit, corr, elig;
    logic [3:0]        n_eff;
    logic [7:0]        n_mask;

    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic [ACC_W-1:0]  evt_acc_q, evt_acc_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              found, load;
    logic [CH_W-1:0]   sel;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        noise_lfsr32 #(
            .SEED(SEED ^ 32'(32'(g) * SEED_SPREAD))
        ) u_lfsr (
            .clk       (clk),
            .rst_n     (rst_n),
            .lfsr_low_o(lfsr_low[g])
        );
    end

    always_comb begin
        hit    = '0;
        n_eff  = clamp_prob(prob_sel);
        n_mask = hit_mask(n_eff);
        corr   = corr_valid ? corr_mask : '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = (n_eff != 4'd0) && ((lfsr_low[i] & n_mask) == n_mask);
        end
    end

    // Round-robin pick; a channel being corrected this cycle is not eligible.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        elig  = pend_q & ~corr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
        load = found && (!evt_valid_q || evt_ready);
    end

    always_comb begin
        err_d  = err_q;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            if (load && (sel == CH_W'(i))) pend_d[i] = 1'b0;
            if (corr[i]) begin
                acc_d[i]  = '0;
                err_d[i]  = 1'b0;
                pend_d[i] = 1'b0;
            end else if (enable_evolution && !err_q[i]) begin
                if (hit[i]) acc_d[i] = sat_inc(acc_q[i]);
                if (acc_q[i] >= threshold) begin
                    err_d[i]  = 1'b1;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_acc_d   = evt_acc_q;
        rr_d        = rr_q;
        if (!evt_valid_q || evt_ready) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d  = sel;
                evt_acc_d = acc_q[sel];
                rr_d      = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
            err_q       <= '0;
            pend_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_acc_q   <= '0;
            rr_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
            err_q       <= err_d;
            pend_q      <= pend_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_acc_q   <= evt_acc_d;
            rr_q        <= rr_d;
        end
    end

    assign error_state = err_q;
    assign evt_valid   = evt_valid_q;
    assign evt_ch      = evt_ch_q;
    assign evt_acc     = evt_acc_q;

endmodule

// File: tb/tb_noise_channel_array.sv
// Scoreboard bench for noise_channel_array (4 channels): directed phases push
// expected events, a negedge monitor pops them as the DUT hands them over.
module tb_noise_channel_array;

    localparam int          NCH  = 4;
    localparam int          AW   = 16;
    localparam logic [31:0] SEED = 32'hDEAD_BEEF;

    logic           clk;
    logic           rst_n;
    logic           enable_evolution;
    logic [3:0]     prob_sel;
    logic [AW-1:0]  threshold;
    logic           corr_valid;
    logic [NCH-1:0] corr_mask;
    logic [NCH-1:0] error_state;
    logic           evt_valid;
    logic           evt_ready;
    logic [1:0]     evt_ch;
    logic [AW-1:0]  evt_acc;

    noise_channel_array #(.NUM_CH(NCH), .ACC_W(AW), .SEED(SEED)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_evolution(enable_evolution),
        .prob_sel        (prob_sel),
        .threshold       (threshold),
        .corr_valid      (corr_valid),
        .corr_mask       (corr_mask),
        .error_state     (error_state),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_ch          (evt_ch),
        .evt_acc         (evt_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int lo;
        int hi;
        bit any;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    int   exp_acc[NCH];

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Edges since reset release; the value before edge m equals m.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [31:0] seed_of(input int ch);
        return SEED ^ 32'(32'(ch) * 32'h9E37_79B9);
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] v, input logic [31:0] s);
        if (v == 32'h0) return s ^ 32'h1;
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Hits a channel sees on edges a .. a+k-1 for hit exponent p.
    function automatic int count_hits(input int ch, input int a, input int k, input int p);
        logic [31:0] s, v, m;
        int n, cnt;
        s = seed_of(ch);
        v = s;
        for (int j = 0; j < a; j++) v = nxt(v, s);
        n = (p > 8) ? 8 : p;
        m = (32'h1 << n) - 32'h1;
        cnt = 0;
        for (int j = 0; j < k; j++) begin
            if (n != 0 && (v & m) == m) cnt++;
            v = nxt(v, s);
        end
        return cnt;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("evt_unexpected_ch", 1'b0, evt_ch, -1);
            end else if (q[0].any) begin
                int idx;
                idx = -1;
                for (int i = 0; i < q.size(); i++)
                    if (idx < 0 && q[i].ch == int'(evt_ch)) idx = i;
                check("evt_ch_known", idx >= 0, evt_ch, q[0].ch);
                if (idx >= 0) begin
                    check("evt_acc_range", int'(evt_acc) >= q[idx].lo && int'(evt_acc) <= q[idx].hi,
                          evt_acc, q[idx].lo);
                    q.delete(idx);
                end
            end else begin
                exp_t e;
                e = q.pop_front();
                check("evt_ch", int'(evt_ch) == e.ch, evt_ch, e.ch);
                check("evt_acc", int'(evt_acc) >= e.lo && int'(evt_acc) <= e.hi, evt_acc, e.lo);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int ch, input int lo, input int hi, input bit any);
        exp_t e;
        e.ch = ch; e.lo = lo; e.hi = hi; e.any = any;
        q.push_back(e);
    endtask

    task automatic push_ordered_all();
        for (int c = 0; c < NCH; c++) push(c, exp_acc[c], exp_acc[c], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable_evolution = 1'b0;
        prob_sel = 4'd0;
        threshold = '0;
        corr_valid = 1'b0;
        corr_mask = '0;
        evt_ready = 1'b0;
        q.delete();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (q.size() != 0 && t < budget) begin
            step(1);
            t++;
        end
        check(name, q.size() == 0, q.size(), 0);
        q.delete();
    endtask

    // Accumulate k edges with an unreachable threshold, then trigger every
    // channel not in cmask on one edge with no hit possible, so each event
    // carries exactly the number of hits counted over the window.
    task automatic run_accum(input int p, input int k, input logic [NCH-1:0] cmask);
        int a;
        a = cyc;
        for (int c = 0; c < NCH; c++) exp_acc[c] = count_hits(c, a, k, p);
        enable_evolution = 1'b1;
        prob_sel = 4'(p);
        threshold = '1;
        corr_valid = 1'b0;
        step(k);
        prob_sel = 4'd0;
        threshold = '0;
        corr_valid = (cmask != '0);
        corr_mask = cmask;
        step(1);
        enable_evolution = 1'b0;
        corr_valid = 1'b0;
        corr_mask = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        bit bad, held, unstable;
        logic [1:0]    hch;
        logic [AW-1:0] hacc;

        rst_n = 1'b0;
        enable_evolution = 1'b0;
        prob_sel = 4'd0;
        threshold = '0;
        corr_valid = 1'b0;
        corr_mask = '0;
        evt_ready = 1'b0;
        step(2);
        check("rst_error_state", error_state == '0, error_state, 0);
        check("rst_evt_valid", evt_valid == 1'b0, evt_valid, 0);
        check("rst_evt_ch_acc", evt_ch == '0 && evt_acc == '0, evt_acc, 0);
        rst_n = 1'b1;

        // Hits disabled: 1000 cycles of evolution must stay silent.
        evt_ready = 1'b1;
        enable_evolution = 1'b1;
        prob_sel = 4'd0;
        threshold = 16'd1;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (error_state != '0 || evt_valid) bad = 1'b1;
        end
        check("idle_silent", !bad, bad, 0);
        run_accum(0, 0, '0);
        push_ordered_all();
        wait_drain("idle_acc_zero_drain", 20);

        // threshold=0 trigger: flags one edge later, events on consecutive cycles.
        do_reset();
        evt_ready = 1'b1;
        run_accum(0, 0, '0);
        check("thr0_error_state", error_state == 4'hF, error_state, 15);
        push_ordered_all();
        for (int k = 0; k < NCH; k++) begin
            step(1);
            check("thr0_consecutive", evt_valid && int'(evt_ch) == k, {evt_valid, evt_ch}, 4 + k);
        end
        wait_drain("thr0_drain", 10);
        step(3);
        check("thr0_slot_empty", evt_valid == 1'b0, evt_valid, 0);

        // Exact hit counts at P=1/4 and with a clamped exponent.
        do_reset();
        evt_ready = 1'b1;
        run_accum(2, 60, '0);
        push_ordered_all();
        wait_drain("p2_drain", 20);
        do_reset();
        evt_ready = 1'b1;
        run_accum(12, 700, '0);
        push_ordered_all();
        wait_drain("p12_clamp_drain", 20);

        // P=1/2, threshold 5, consumer stalled.
        do_reset();
        evt_ready = 1'b0;
        for (int c = 0; c < NCH; c++) push(c, 5, 6, 1'b1);
        prob_sel = 4'd1;
        threshold = 16'd5;
        enable_evolution = 1'b1;
        held = 1'b0;
        unstable = 1'b0;
        hch = '0;
        hacc = '0;
        for (int i = 0; i < 2000 && error_state != 4'hF; i++) begin
            step(1);
            if (evt_valid && !held) begin
                held = 1'b1;
                hch = evt_ch;
                hacc = evt_acc;
            end else if (held && (!evt_valid || evt_ch != hch || evt_acc != hacc)) begin
                unstable = 1'b1;
            end
        end
        check("p1_all_latched", error_state == 4'hF, error_state, 15);
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (!evt_valid || evt_ch != hch || evt_acc != hacc || error_state != 4'hF) unstable = 1'b1;
        end
        check("p1_slot_stable", held && !unstable, unstable, 0);
        evt_ready = 1'b1;
        wait_drain("p1_one_each_drain", 20);
        step(10);
        enable_evolution = 1'b0;

        // Correction wins over ch2's trigger.
        do_reset();
        evt_ready = 1'b1;
        run_accum(0, 0, 4'b0100);
        check("corr_trig_state", error_state == 4'b1011, error_state, 11);
        push(0, 0, 0, 1'b0);
        push(1, 0, 0, 1'b0);
        push(3, 0, 0, 1'b0);
        wait_drain("corr_trig_drain", 20);
        step(5);
        check("corr_trig_hold", error_state == 4'b1011, error_state, 11);

        // Correcting ch1 while its event sits in the slot.
        do_reset();
        evt_ready = 1'b0;
        run_accum(1, 20, 4'b1101);
        check("slot_corr_state", error_state == 4'b0010, error_state, 2);
        step(1);
        check("slot_loaded_ch1", evt_valid && evt_ch == 2'd1, {evt_valid, evt_ch}, 5);
        check("slot_loaded_acc", int'(evt_acc) == exp_acc[1], evt_acc, exp_acc[1]);
        corr_valid = 1'b1;
        corr_mask = 4'b0010;
        step(1);
        corr_valid = 1'b0;
        corr_mask = '0;
        check("slot_corr_cleared", error_state == '0, error_state, 0);
        check("slot_kept_acc", evt_valid && int'(evt_acc) == exp_acc[1], evt_acc, exp_acc[1]);
        push(1, exp_acc[1], exp_acc[1], 1'b0);
        evt_ready = 1'b1;
        wait_drain("slot_corr_drain", 10);
        step(6);
        run_accum(0, 0, 4'b1101);
        push(1, 0, 0, 1'b0);
        wait_drain("slot_retrigger_drain", 10);

        // Asynchronous reset with undelivered events, then identical replay.
        do_reset();
        evt_ready = 1'b0;
        run_accum(0, 0, '0);
        step(1);
        check("pre_rst_slot", evt_valid == 1'b1, evt_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_err", error_state == '0, error_state, 0);
        check("async_rst_evt", evt_valid == 1'b0 && evt_ch == '0 && evt_acc == '0, evt_acc, 0);
        q.delete();
        step(2);
        evt_ready = 1'b1;
        rst_n = 1'b1;
        step(5);
        check("post_rst_no_stale", evt_valid == 1'b0 && error_state == '0, evt_valid, 0);
        do_reset();
        evt_ready = 1'b1;
        run_accum(3, 100, '0);
        push_ordered_all();
        wait_drain("replay_drain", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/noise_channel_array.md
NOISE_CHANNEL_ARRAY -- requirements
Module: noise_channel_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of independent noise channels, range 1..32.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width per channel.
REQ-003 SHALL have parameter SEED, default 32'hDEAD_BEEF: base LFSR seed.
REQ-004 SHALL have port clk  input  1: system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port enable_evolution  input  1: global accumulation enable.
REQ-007 SHALL have port prob_sel  input  4: hit-probability exponent n (P=2^-n).
REQ-008 SHALL have port threshold  input  ACC_W: runtime trigger level.
REQ-009 SHALL have port corr_valid  input  1: apply correction this cycle.
REQ-010 SHALL have port corr_mask  input  NUM_CH: channels to correct.
REQ-011 SHALL have port error_state  output  NUM_CH: per-channel latched error flag.
REQ-012 SHALL have ports evt_valid  output  1, evt_ready  input  1, evt_ch  output  $clog2(NUM_CH) (min 1), and evt_acc  output  ACC_W: the error-event stream.

Function
REQ-013 Each channel SHALL own a 32-bit LFSR seeded with SEED ^ (ch * 32'h9E37_79B9).
REQ-014 The LFSR SHALL shift left every cycle with feedback lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0], independent of enable_evolution.
REQ-015 An all-zero LFSR SHALL be reloaded with its seed ^ 32'h1.
REQ-016 A hit SHALL occur when the low n LFSR bits are all ones.
REQ-017 prob_sel=0 SHALL produce no hits; values above 8 SHALL be treated as 8.
REQ-018 When enable_evolution=1, error_state[i]=0, and channel i hits, acc[i] SHALL increment by 1, saturating at all-ones.
REQ-019 When enable_evolution=1, error_state[i]=0, and registered acc[i] >= threshold, error_state[i] and pending[i] SHALL set on the next edge (1-cycle latency).
REQ-020 threshold=0 SHALL trigger one cycle after enable.
REQ-021 A set error_state[i] SHALL freeze acc[i] until corrected.
REQ-022 corr_valid with corr_mask[i]=1 SHALL clear acc[i], error_state[i], and pending[i] on the next edge; correction SHALL win over a simultaneous increment or trigger.
REQ-023 Event output SHALL be a single registered slot: when empty or being popped (evt_valid&&evt_ready) and any pending[i]=1, load the first pending channel at or after rr_ptr (round-robin).
REQ-024 The slot load SHALL set evt_ch=i and evt_acc=acc[i], clear pending[i], and set rr_ptr=(i+1) mod NUM_CH.
REQ-025 evt_ch and evt_acc SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-026 A correction SHALL NOT retract an event already loaded in the slot.
REQ-027 Back-to-back pops SHALL deliver one event per cycle while pending events remain.
REQ-028 Each channel SHALL report exactly one event per error rising edge.

Reset
REQ-029 On rst_n low, asynchronously: every lfsr = its seed, acc=0, error_state=0, pending=0, rr_ptr=0, evt_valid=0, evt_ch=0, evt_acc=0.
REQ-030 Reset mid-operation SHALL discard any undelivered events.
REQ-031 Outputs SHALL be valid from the first edge after rst_n rises.

Structure
REQ-032 Package noise_pkg SHALL hold: LFSR taps, the seed-spread constant, the prob_sel clamp value (8), and the default NUM_CH/ACC_W.
REQ-033 Sub-module noise_lfsr32 (seed parameter, zero-lockup recovery) SHALL be instantiated once per channel via generate.
REQ-034 Accumulators, flags, and the arbiter SHALL live in the top level.

Verification
REQ-035 NUM_CH=4, prob_sel=0, enable=1, 1000 cycles -> all acc=0, error_state=0, evt_valid never 1.
REQ-036 threshold=0, enable=1 -> error_state=4'hF after 1 cycle; with evt_ready=1, events delivered with evt_ch=0,1,2,3 on consecutive cycles, evt_acc=0.
REQ-037 prob_sel=1, threshold=5, evt_ready=0 -> each channel latches at acc=5 or 6 (at most 1 extra hit during the trigger cycle); acc stays frozen after the latch; exactly one event per channel, held stable until ready.
REQ-038 Apply corr_valid with mask=4'b0100 in the same cycle ch2 would trigger -> error_state[2]=0, acc[2]=0, no ch2 event.
REQ-039 Event for ch1 in the slot; correct ch1 -> event still delivered with its captured evt_acc; ch1 is not re-reported until it triggers again.
REQ-040 Assert rst_n low mid-stream with 3 pending events -> all outputs 0 asynchronously; LFSR sequences replay identically after release.
